// File: rtl/boot_sequencer.sv
// ---------------------------------------------------------------------------
// boot_sequencer
//
// Boot controller between an external program loader and the core. It holds
// the core in reset and accepts instruction words over a valid/ready
// handshake. Each word goes into the instruction memory write port at
// consecutive word addresses. After the last word and a settle delay, the
// core is released. A restart request from RUN or ERROR reloads the program.
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   ld_valid      in   loader word valid
//   ld_ready      out  sequencer accepts a word this cycle (LOAD only)
//   ld_data       in   instruction word
//   ld_last       in   final word of the program
//   restart       in   reload request, honoured in RUN or ERROR
//   imem_wr_en    out  instruction memory write strobe (one cycle per beat)
//   imem_wr_addr  out  word-aligned byte write address
//   imem_wr_data  out  write data
//   core_rst_n    out  registered active-low core reset
//   done          out  program loaded, core running
//   error         out  MAX_WORDS accepted without ld_last
//   word_count    out  words accepted in the current load
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module boot_sequencer #(
    parameter int                    ADDR_WIDTH    = 32,
    parameter int                    WORD_WIDTH    = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
    parameter int                    MAX_WORDS     = 1024,
    parameter int                    RELEASE_DELAY = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               ld_valid,
    output logic                               ld_ready,
    input  logic [WORD_WIDTH-1:0]              ld_data,
    input  logic                               ld_last,
    input  logic                               restart,
    output logic                               imem_wr_en,
    output logic [ADDR_WIDTH-1:0]              imem_wr_addr,
    output logic [WORD_WIDTH-1:0]              imem_wr_data,
    output logic                               core_rst_n,
    output logic                               done,
    output logic                               error,
    output logic [$clog2(MAX_WORDS+1)-1:0]     word_count
);

    localparam int CNT_W = $clog2(MAX_WORDS + 1);
    localparam int DLY_W = $clog2(RELEASE_DELAY + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        RUN    = 3'd3,
        ERROR  = 3'd4
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [DLY_W-1:0]   dly;
    logic               beat;
    logic               reload;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        next_state = state;
        ld_ready   = (state == LOAD);
        beat       = ld_valid && (state == LOAD);
        reload     = restart && ((state == RUN) || (state == ERROR));
        case (state)
            IDLE:   next_state = LOAD;
            LOAD: begin
                if (beat) begin
                    // A last word always wins, so exactly MAX_WORDS words is a
                    // legal program; only a non-last word in the final slot
                    // overflows.
                    if (ld_last) begin
                        next_state = SETTLE;
                    end else if (word_count == LAST_IDX) begin
                        next_state = ERROR;
                    end
                end
            end
            SETTLE: begin
                if (dly == DLY_W'(1)) begin
                    next_state = RUN;
                end
            end
            RUN, ERROR: begin
                if (restart) begin
                    next_state = LOAD;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Write port, counters and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_wr_en   <= 1'b0;
            imem_wr_addr <= BASE_ADDR;
            imem_wr_data <= '0;
            word_count   <= '0;
            dly          <= '0;
            core_rst_n   <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            imem_wr_en <= beat;
            if (beat) begin
                // Address is taken from the count before the increment, so the
                // first word lands at BASE_ADDR. Wraps at ADDR_WIDTH.
                imem_wr_addr <= BASE_ADDR + (ADDR_WIDTH'(word_count) << 2);
                imem_wr_data <= ld_data;
                word_count   <= word_count + CNT_W'(1);
            end else if (reload) begin
                word_count <= '0;
            end

            if (beat && ld_last) begin
                dly <= DLY_W'(RELEASE_DELAY);
            end else if (state == SETTLE) begin
                dly <= dly - DLY_W'(1);
            end

            // Status flags follow the state being entered so they change on
            // the same edge as the state itself.
            core_rst_n <= (next_state == RUN);
            done       <= (next_state == RUN);
            error      <= (next_state == ERROR);
        end
    end

endmodule
